// File: rtl/fwd_scoreboard.sv
// Register scoreboard for the EX stage: tracks in-flight producer latency per register,
// raises a stall on unresolved RAW hazards and selects MEM/WB forwarding per source.
module fwd_scoreboard #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5,
  parameter int MAX_LAT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic [REG_AW-1:0]             issue_rd,
  input  logic                          issue_regwrite,
  input  logic [$clog2(MAX_LAT+1)-1:0]  issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0]     ex_rs,
  input  logic [REG_AW-1:0]             mem_rd,
  input  logic                          mem_regwrite,
  input  logic [REG_AW-1:0]             wb_rd,
  input  logic                          wb_regwrite,
  input  logic                          flush,
  output logic [2*NUM_SRC-1:0]          fwd_sel,
  output logic                          stall,
  output logic [REG_AW:0]               pending_cnt,
  output logic [15:0]                   stall_cycles
);

  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int NREG  = 2 ** REG_AW;
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0]  LAT_MAX  = LAT_W'(MAX_LAT);
  localparam logic [REG_AW:0]   PEND_ONE = (REG_AW+1)'(1);

  logic [LAT_W-1:0]  r_cnt [NREG];
  logic [LAT_W-1:0]  w_cntNext [NREG];
  logic [REG_AW-1:0] w_rs [NUM_SRC];
  logic [LAT_W-1:0]  w_latEff;
  logic [NUM_SRC-1:0] w_hazard;
  logic [2*NUM_SRC-1:0] w_fwdSel;
  logic              w_stall;
  logic              w_accept;
  logic              w_load;
  logic [REG_AW:0]   w_pendNext;
  logic [REG_AW:0]   r_pendCnt;
  logic [15:0]       r_stallCycles;

  // Zero latency still occupies one cycle; anything beyond the pipeline depth is clamped.
  always_comb begin
    w_latEff = issue_lat;
    if (issue_lat == '0) begin
      w_latEff = LAT_ONE;
    end else if (issue_lat > LAT_MAX) begin
      w_latEff = LAT_MAX;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_rs[i] = ex_rs[i*REG_AW +: REG_AW];
    end
  end

  // A counter of 1 means the result is in MEM next cycle and can be forwarded, so no stall.
  always_comb begin
    w_hazard = '0;
    w_fwdSel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_hazard[i] = (w_rs[i] != '0) && (r_cnt[w_rs[i]] > LAT_ONE);
      if (rst_n) begin
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == w_rs[i])) begin
          w_fwdSel[2*i +: 2] = 2'b10;
        end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == w_rs[i])) begin
          w_fwdSel[2*i +: 2] = 2'b01;
        end
      end
    end
  end

  always_comb begin
    w_stall  = rst_n && !flush && issue_valid && (|w_hazard);
    w_accept = issue_valid && !w_stall && !flush;
    w_load   = w_accept && issue_regwrite && (issue_rd != '0);
  end

  // Flush wins over load, and a load to a register wins over its own decrement.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_cntNext[r] = '0;
      if (!flush && (r != 0)) begin
        if (w_load && (issue_rd == REG_AW'(r))) begin
          w_cntNext[r] = w_latEff;
        end else if (r_cnt[r] != '0) begin
          w_cntNext[r] = r_cnt[r] - LAT_ONE;
        end
      end
    end
  end

  always_comb begin
    w_pendNext = '0;
    for (int r = 1; r < NREG; r++) begin
      if (w_cntNext[r] != '0) begin
        w_pendNext = w_pendNext + PEND_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
      r_pendCnt     <= '0;
      r_stallCycles <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_cntNext[r];
      end
      r_pendCnt <= w_pendNext;
      if (w_stall && (r_stallCycles != 16'hFFFF)) begin
        r_stallCycles <= r_stallCycles + 16'd1;
      end
    end
  end

  assign fwd_sel      = w_fwdSel;
  assign stall        = w_stall;
  assign pending_cnt  = r_pendCnt;
  assign stall_cycles = r_stallCycles;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: forwarding priority, multi-cycle stalls, register 0,
// flush, load override, asynchronous reset and stall counter saturation.
module tb_fwd_scoreboard;

  localparam int NUM_SRC = 2;
  localparam int REG_AW  = 5;
  localparam int MAX_LAT = 15;
  localparam int LAT_W   = 4;

  logic                      clk   = 1'b0;
  logic                      rst_n = 1'b1;
  logic                      issue_valid    = 1'b0;
  logic [REG_AW-1:0]         issue_rd       = '0;
  logic                      issue_regwrite = 1'b0;
  logic [LAT_W-1:0]          issue_lat      = '0;
  logic [NUM_SRC*REG_AW-1:0] ex_rs          = '0;
  logic [REG_AW-1:0]         mem_rd         = '0;
  logic                      mem_regwrite   = 1'b0;
  logic [REG_AW-1:0]         wb_rd          = '0;
  logic                      wb_regwrite    = 1'b0;
  logic                      flush          = 1'b0;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      stall;
  logic [REG_AW:0]           pending_cnt;
  logic [15:0]               stall_cycles;

  int errors = 0;
  int checks = 0;

  fwd_scoreboard #(
    .NUM_SRC(NUM_SRC),
    .REG_AW (REG_AW),
    .MAX_LAT(MAX_LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_rd      (issue_rd),
    .issue_regwrite(issue_regwrite),
    .issue_lat     (issue_lat),
    .ex_rs         (ex_rs),
    .mem_rd        (mem_rd),
    .mem_regwrite  (mem_regwrite),
    .wb_rd         (wb_rd),
    .wb_regwrite   (wb_regwrite),
    .flush         (flush),
    .fwd_sel       (fwd_sel),
    .stall         (stall),
    .pending_cnt   (pending_cnt),
    .stall_cycles  (stall_cycles)
  );

  initial forever #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [REG_AW-1:0] rd, input logic wr,
                               input logic [LAT_W-1:0] lat, input logic [REG_AW-1:0] rs0,
                               input logic [REG_AW-1:0] rs1);
    issue_valid    = v;
    issue_rd       = rd;
    issue_regwrite = wr;
    issue_lat      = lat;
    ex_rs          = {rs1, rs0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with forwarding-looking inputs applied: outputs must stay quiet.
    #2;
    rst_n        = 1'b0;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd5;
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd5, 5'd0);
    checkOutput("rst_fwd", 32'(fwd_sel), 32'h0);
    checkOutput("rst_stall", 32'(stall), 32'h0);
    checkOutput("rst_pending", 32'(pending_cnt), 32'h0);
    checkOutput("rst_stallcyc", 32'(stall_cycles), 32'h0);
    tick();
    mem_regwrite = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    rst_n = 1'b1;
    tick();

    // MEM over WB priority, WB fallback, register 0 never forwarded.
    mem_rd = 5'd5; wb_rd = 5'd5; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd5, 5'd0);
    checkOutput("fwd_mem_prio", 32'(fwd_sel), 32'h2);
    mem_regwrite = 1'b0;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd5, 5'd0);
    checkOutput("fwd_wb", 32'(fwd_sel), 32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd5);
    checkOutput("fwd_src1_wb", 32'(fwd_sel), 32'h4);
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    checkOutput("fwd_rs0_zero", 32'(fwd_sel), 32'h0);
    mem_rd = 5'd3; wb_rd = 5'd4; mem_regwrite = 1'b1;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd3, 5'd4);
    checkOutput("fwd_mixed", 32'(fwd_sel), 32'h6);
    mem_rd = 5'd0; wb_rd = 5'd0;
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    checkOutput("fwd_x0_dest", 32'(fwd_sel), 32'h0);
    mem_regwrite = 1'b0; wb_regwrite = 1'b0;

    // Latency-3 producer stalls a dependent consumer for two cycles.
    applyStimulus(1'b1, 5'd7, 1'b1, 4'd3, 5'd0, 5'd0);
    checkOutput("lat3_issue_stall", 32'(stall), 32'h0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd7, 5'd0);
    checkOutput("lat3_stall_c1", 32'(stall), 32'h1);
    checkOutput("lat3_pending", 32'(pending_cnt), 32'h1);
    tick();
    checkOutput("lat3_stall_c2", 32'(stall), 32'h1);
    checkOutput("lat3_stallcyc1", 32'(stall_cycles), 32'h1);
    tick();
    checkOutput("lat3_stall_c3", 32'(stall), 32'h0);
    checkOutput("lat3_stallcyc2", 32'(stall_cycles), 32'h2);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    checkOutput("lat3_drained", 32'(pending_cnt), 32'h0);

    // Writes to register 0 are never tracked.
    applyStimulus(1'b1, 5'd0, 1'b1, 4'd4, 5'd0, 5'd0);
    checkOutput("x0_issue_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("x0_pending", 32'(pending_cnt), 32'h0);
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    checkOutput("x0_read_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("x0_pending2", 32'(pending_cnt), 32'h0);

    // Latency 0 behaves as 1: tracked one cycle, forwardable, no stall.
    applyStimulus(1'b1, 5'd4, 1'b1, 4'd0, 5'd0, 5'd0);
    tick();
    checkOutput("lat0_pending", 32'(pending_cnt), 32'h1);
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd4, 5'd0);
    checkOutput("lat0_no_stall", 32'(stall), 32'h0);
    tick();
    checkOutput("lat0_drained", 32'(pending_cnt), 32'h0);

    // Flush with x3 and x9 pending; the flushed-cycle issue to x12 must be dropped.
    applyStimulus(1'b1, 5'd3, 1'b1, 4'd4, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b1, 4'd2, 5'd0, 5'd0);
    tick();
    checkOutput("flush_pending2", 32'(pending_cnt), 32'h2);
    applyStimulus(1'b0, 5'd12, 1'b1, 4'd5, 5'd3, 5'd0);
    checkOutput("flush_novalid", 32'(stall), 32'h0);
    applyStimulus(1'b1, 5'd12, 1'b1, 4'd5, 5'd3, 5'd0);
    checkOutput("flush_pre_stall", 32'(stall), 32'h1);
    flush = 1'b1;
    #1;
    checkOutput("flush_forces_low", 32'(stall), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush_pending0", 32'(pending_cnt), 32'h0);
    checkOutput("flush_rs3_stall", 32'(stall), 32'h0);
    checkOutput("flush_stallcyc", 32'(stall_cycles), 32'h2);

    // Reissue to the same register reloads over the decrement.
    applyStimulus(1'b1, 5'd9, 1'b1, 4'd2, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b1, 4'd5, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd0, 5'd9);
    checkOutput("reload_stall_src1", 32'(stall), 32'h1);
    checkOutput("reload_pending", 32'(pending_cnt), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    checkOutput("reload_flushed", 32'(pending_cnt), 32'h0);

    // Asynchronous reset between edges clears everything at once.
    applyStimulus(1'b1, 5'd6, 1'b1, 4'd8, 5'd0, 5'd0);
    tick();
    mem_rd = 5'd6; mem_regwrite = 1'b1;
    applyStimulus(1'b1, 5'd0, 1'b0, 4'd0, 5'd6, 5'd0);
    checkOutput("arst_pre_stall", 32'(stall), 32'h1);
    checkOutput("arst_pre_fwd", 32'(fwd_sel), 32'h2);
    checkOutput("arst_pre_pending", 32'(pending_cnt), 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_stall", 32'(stall), 32'h0);
    checkOutput("arst_fwd", 32'(fwd_sel), 32'h0);
    checkOutput("arst_pending", 32'(pending_cnt), 32'h0);
    checkOutput("arst_stallcyc", 32'(stall_cycles), 32'h0);
    tick();
    mem_regwrite = 1'b0; mem_rd = 5'd0;
    applyStimulus(1'b1, 5'd10, 1'b1, 4'd3, 5'd6, 5'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("arst_x6_cleared", 32'(stall), 32'h0);
    tick();
    checkOutput("first_issue_pending", 32'(pending_cnt), 32'h1);
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);
    tick();
    tick();
    tick();
    checkOutput("first_issue_drained", 32'(pending_cnt), 32'h0);

    // Self-dependent latency-15 loop: 14 stall cycles out of every 15 edges.
    applyStimulus(1'b1, 5'd7, 1'b1, 4'd15, 5'd7, 5'd0);
    for (int n = 0; n < 30; n++) tick();
    checkOutput("sat_after30", 32'(stall_cycles), 32'd28);
    for (int n = 30; n < 70216; n++) tick();
    checkOutput("sat_almost", 32'(stall_cycles), 32'hFFFE);
    tick();
    checkOutput("sat_reached", 32'(stall_cycles), 32'hFFFF);
    for (int n = 0; n < 300; n++) tick();
    checkOutput("sat_holds", 32'(stall_cycles), 32'hFFFF);
    applyStimulus(1'b0, 5'd0, 1'b0, 4'd0, 5'd0, 5'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2: number of EX source operands checked per cycle (1..4).
REQ-002 Parameter REG_AW, default 5: register address width; register file depth 2**REG_AW.
REQ-003 Parameter MAX_LAT, default 4: maximum producer latency in cycles (1..15); LAT_W = clog2(MAX_LAT+1).
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-006 Port issue_valid  input  1: an instruction is presented for EX entry this cycle.
REQ-007 Port issue_rd  input  REG_AW: destination register of the presented instruction.
REQ-008 Port issue_regwrite  input  1: presented instruction writes issue_rd.
REQ-009 Port issue_lat  input  LAT_W: cycles until the result reaches MEM-stage forwarding; 1 = ALU op.
REQ-010 Port ex_rs  input  NUM_SRC*REG_AW: source register addresses; source i at bits [i*REG_AW +: REG_AW].
REQ-011 Port mem_rd / mem_regwrite  input  REG_AW / 1: MEM-stage destination and write enable.
REQ-012 Port wb_rd / wb_regwrite  input  REG_AW / 1: WB-stage destination and write enable.
REQ-013 Port flush  input  1: synchronous pipeline flush; discards all pending writes.
REQ-014 Port fwd_sel  output  2*NUM_SRC: forward select per source, bits [2i+1:2i]; 00 regfile, 10 MEM, 01 WB.
REQ-015 Port stall  output  1: presented instruction must not enter EX this cycle.
REQ-016 Port pending_cnt  output  REG_AW+1: number of registers with nonzero pending counter.
REQ-017 Port stall_cycles  output  16: saturating count of cycles with stall high.

Function
REQ-018 One LAT_W-bit pending counter per register; counter for register 0 is constant 0.
REQ-019 Accept = issue_valid && !stall && !flush; on accept with issue_regwrite and issue_rd != 0, counter[issue_rd] loads issue_lat at the next edge.
REQ-020 Every other nonzero counter decrements by 1 per cycle regardless of stall.
REQ-021 A load to the same register overrides its decrement in that cycle.
REQ-022 issue_lat = 0 is treated as 1; values above MAX_LAT are clamped to MAX_LAT.
REQ-023 Source i is hazardous when ex_rs[i] != 0 and counter[ex_rs[i]] > 1; stall = issue_valid && any hazardous source, combinational.
REQ-024 fwd_sel[i] = 10 when mem_regwrite && mem_rd != 0 && mem_rd == ex_rs[i].
REQ-025 Otherwise fwd_sel[i] = 01 when wb_regwrite && wb_rd != 0 && wb_rd == ex_rs[i]; otherwise 00. MEM has priority over WB.
REQ-026 fwd_sel is combinational with zero-cycle latency, independent of stall.
REQ-027 flush clears all counters at the next edge, takes priority over load and decrement, and forces stall low in the same cycle.
REQ-028 pending_cnt is registered and reflects counter state after the current edge.
REQ-029 stall_cycles increments on each edge where stall is high and saturates at 16'hFFFF; flush does not clear it.

Reset
REQ-030 While rst_n is low: all counters 0, pending_cnt 0, stall_cycles 0.
REQ-031 While rst_n is low: stall 0 and fwd_sel all 00, regardless of inputs.
REQ-032 Reset asserted mid-operation discards all pending writes immediately, without waiting for a clock edge.
REQ-033 The first accepted issue is the one presented on the first rising edge after rst_n deasserts.

Verification
REQ-034 MEM/WB priority: mem_rd=wb_rd=5, both regwrite, ex_rs[0]=5 -> fwd_sel[1:0]=10; drop mem_regwrite -> 01; ex_rs[0]=0 -> 00.
REQ-035 Multi-cycle stall: accept issue rd=7, lat=3; next cycle present rs0=7 -> stall high for exactly 2 cycles, then low; stall_cycles=2.
REQ-036 Register 0: issue rd=0, lat=4, then present rs0=0 -> stall never asserts, pending_cnt stays 0.
REQ-037 Flush: pending writes to x3 (lat 4) and x9 (lat 2), pulse flush -> next cycle pending_cnt=0; rs0=3 gives no stall.
REQ-038 Async reset: counters loaded, drop rst_n between edges -> stall, pending_cnt and fwd_sel go to 0 immediately.
REQ-039 Saturation: hold stall high for 70000 cycles -> stall_cycles reads 16'hFFFF and holds.
